// File: rtl/bt_pkg.sv
// Shared trit codes, op codes, FSM states and trit helpers for the
// balanced-ternary serial adder/accumulator.
package bt_pkg;

    // Trit encodings
    localparam logic [1:0] T_ZERO = 2'b11;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b10;
    localparam logic [1:0] T_BAD  = 2'b00;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Negate one trit: swap +1/-1, leave 0 and the illegal code alone
    function automatic logic [1:0] trit_neg(input logic [1:0] t);
        case (t)
            T_POS:   return T_NEG;
            T_NEG:   return T_POS;
            default: return t;
        endcase
    endfunction

    function automatic logic trit_is_bad(input logic [1:0] t);
        return (t == T_BAD);
    endfunction

    // Trit value as 3-bit two's complement; the illegal code counts as 0
    function automatic logic [2:0] trit_val(input logic [1:0] t);
        case (t)
            T_POS:   return 3'b001;
            T_NEG:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/bta_serial_accum_if.sv
// Request/response bus of the balanced-ternary serial accumulator.
interface bta_serial_accum_if #(
    parameter int unsigned N_TRITS = 8
);
    localparam int unsigned W = 2 * N_TRITS;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic [1:0]   cout;
    logic         illegal;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, illegal
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, illegal
    );

endinterface

// File: rtl/bt_full_adder.sv
// Combinational balanced-ternary full adder: (x + y + c) -> (s, co).
module bt_full_adder
    import bt_pkg::*;
(
    input  logic [1:0] i_x,
    input  logic [1:0] i_y,
    input  logic [1:0] i_c,
    output logic [1:0] o_s,
    output logic [1:0] o_co
);

    logic [2:0] w_v;

    // Sum in -3..+3, folded into a balanced digit and a carry trit
    always_comb begin
        w_v  = trit_val(i_x) + trit_val(i_y) + trit_val(i_c);
        o_s  = T_ZERO;
        o_co = T_ZERO;
        case (w_v)
            3'b101: begin o_s = T_ZERO; o_co = T_NEG;  end  // -3
            3'b110: begin o_s = T_POS;  o_co = T_NEG;  end  // -2
            3'b111: begin o_s = T_NEG;  o_co = T_ZERO; end  // -1
            3'b001: begin o_s = T_POS;  o_co = T_ZERO; end  // +1
            3'b010: begin o_s = T_NEG;  o_co = T_POS;  end  // +2
            3'b011: begin o_s = T_ZERO; o_co = T_POS;  end  // +3
            default: begin o_s = T_ZERO; o_co = T_ZERO; end
        endcase
    end

endmodule

// File: rtl/bta_serial_accum.sv
// Digit-serial balanced-ternary adder/accumulator, TPC trits per clock,
// least-significant slice first, carry registered between slices.
module bta_serial_accum
    import bt_pkg::*;
#(
    parameter int unsigned N_TRITS = 8,
    parameter int unsigned TPC     = 1
) (
    input  logic             clk,
    input  logic             rst,
    bta_serial_accum_if.slave bus
);

    localparam int unsigned W     = 2 * N_TRITS;
    localparam int unsigned SLW   = 2 * TPC;
    localparam int unsigned K     = N_TRITS / TPC;
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [W-1:0] ALL_ZERO = {N_TRITS{T_ZERO}};

    state_e           r_state;
    op_e              r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_res;
    logic [W-1:0]     r_acc;
    logic [1:0]       r_carry;
    logic [1:0]       r_cout;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_illegal;

    op_e              w_op;
    logic [W-1:0]     w_neg_b;
    logic [W-1:0]     w_b_sel;
    logic [N_TRITS-1:0] w_bad_a;
    logic [N_TRITS-1:0] w_bad_b;
    logic             w_bad;
    logic [1:0]       w_c [TPC+1];
    logic [SLW-1:0]   w_s;
    logic [W-1:0]     w_res_next;

    assign w_op = op_e'(bus.op);

    // Per-trit negation and illegal-code detection of the request operands
    for (genvar g = 0; g < N_TRITS; g++) begin : g_trit
        assign w_neg_b[2*g+1:2*g] = trit_neg(bus.b[2*g+1:2*g]);
        assign w_bad_a[g]         = trit_is_bad(bus.a[2*g+1:2*g]);
        assign w_bad_b[g]         = trit_is_bad(bus.b[2*g+1:2*g]);
    end

    assign w_bad = trit_is_bad(bus.cin)
                 | ((w_op != OP_CLR) & (|w_bad_a))
                 | (((w_op == OP_ADD) | (w_op == OP_SUB)) & (|w_bad_b));

    // Second operand: B, -B, or the accumulator
    always_comb begin
        w_b_sel = bus.b;
        case (w_op)
            OP_SUB:  w_b_sel = w_neg_b;
            OP_ACC:  w_b_sel = r_acc;
            default: w_b_sel = bus.b;
        endcase
    end

    // Ripple chain across the current slice
    assign w_c[0] = r_carry;
    for (genvar g = 0; g < TPC; g++) begin : g_fa
        bt_full_adder u_fa (
            .i_x  (r_a[2*g+1:2*g]),
            .i_y  (r_b[2*g+1:2*g]),
            .i_c  (w_c[g]),
            .o_s  (w_s[2*g+1:2*g]),
            .o_co (w_c[g+1])
        );
    end

    // Result shifts right; the new slice enters at the top so after K
    // slices every trit sits at its own position
    assign w_res_next = (r_res >> SLW) | (W'(w_s) << (W - SLW));

    // Transaction FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_a         <= ALL_ZERO;
            r_b         <= ALL_ZERO;
            r_res       <= ALL_ZERO;
            r_acc       <= ALL_ZERO;
            r_carry     <= T_ZERO;
            r_cout      <= T_ZERO;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_op       <= w_op;
                        r_a        <= bus.a;
                        r_b        <= w_b_sel;
                        r_carry    <= bus.cin;
                        r_cnt      <= '0;
                        r_illegal  <= w_bad;
                        r_in_ready <= 1'b0;
                        if (w_op == OP_CLR) begin
                            r_res       <= ALL_ZERO;
                            r_cout      <= T_ZERO;
                            r_acc       <= ALL_ZERO;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_a     <= r_a >> SLW;
                    r_b     <= r_b >> SLW;
                    r_carry <= w_c[TPC];
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(K - 1)) begin
                        r_cout      <= w_c[TPC];
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                        if (r_op == OP_ACC) begin
                            r_acc <= w_res_next;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_res;
    assign bus.cout      = r_cout;
    assign bus.illegal   = r_illegal;

endmodule
